// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in flight,
// and hands {instr, PC, exc} to IF/ID through an output slot backed by a one-entry skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        out_exc
);

  // REQ: may issue | WAIT: awaiting response | FULL: skid occupied | DRAIN: drop stale response
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_q, exc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        exc_sent_q, exc_sent_d;

  logic pc_bad;
  logic slot_consumed;
  logic slot_free;
  logic req_fire;

  assign pc_bad        = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < IMEM_LO) || (fetch_pc_q > IMEM_HI);
  assign slot_consumed = out_valid_q & ~stall;
  assign slot_free     = ~out_valid_q | slot_consumed;
  assign req_fire      = imem_req & imem_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      out_valid_q  <= 1'b0;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
      exc_q        <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      exc_sent_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      exc_q        <= exc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      exc_sent_q   <= exc_sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = slot_free ? S_REQ : S_FULL;
      S_FULL:  if (slot_consumed) state_d = S_REQ;
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    // A redirect while already draining only retargets the PC; the stale response is still owed.
    if (redirect_valid && state_q != S_DRAIN) begin
      if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && req_fire)) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  always_comb begin
    imem_req  = reset && (state_q == S_REQ) && !pc_bad;
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    out_valid_d  = out_valid_q & ~slot_consumed;
    instr_d      = instr_q;
    pc_d         = pc_q;
    exc_d        = exc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    exc_sent_d   = exc_sent_q;
    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      out_valid_d  = 1'b0;
      skid_instr_d = 32'h0;
      skid_pc_d    = 32'h0;
      exc_sent_d   = 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // The AdEL slot is delivered once; fetch then parks until ID redirects.
          if (pc_bad && !exc_sent_q && slot_free) begin
            out_valid_d = 1'b1;
            instr_d     = 32'h0;
            pc_d        = fetch_pc_q;
            exc_d       = 1'b1;
            exc_sent_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (slot_free) begin
              out_valid_d = 1'b1;
              instr_d     = imem_rdata;
              pc_d        = fetch_pc_q;
              exc_d       = 1'b0;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = fetch_pc_q;
            end
          end
        end
        S_FULL: begin
          if (slot_consumed) begin
            out_valid_d = 1'b1;
            instr_d     = skid_instr_q;
            pc_d        = skid_pc_q;
            exc_d       = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign PC        = pc_q;
  assign out_exc   = exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk-through of the fetch scenarios, then randomized
// stall/redirect/reset traffic checked against an in-order instruction-stream model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] LO       = 32'h0000_3000;
  localparam logic [31:0] HI       = 32'h0000_6FFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] instr, PC;
  logic        out_exc;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_LO(LO), .IMEM_HI(HI)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .instr(instr), .PC(PC), .out_exc(out_exc)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_cons  = 0;

  // Scoreboard: each redirect/reset issued pushes the start of a new in-order stream.
  logic [31:0] seg_q[$];
  logic [31:0] exp_pc = 32'h0;
  bit          blocked = 1'b0;

  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_fix  = 0;
  bit          ready_rand = 1'b0;

  bit          s_acc, s_rsp, s_rst, s_req, s_ov, s_exc;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2408_0001;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every slot IF/ID captures against the stream model.
  always @(negedge clk) begin
    if (!reset || redirect_valid) begin
      check("seg_queue_nonempty", 32'(seg_q.size() != 0), 32'd1);
      if (seg_q.size() != 0) exp_pc = seg_q.pop_front();
      blocked = 1'b0;
    end else if (blocked) begin
      check("idle_after_exc", 32'(out_valid), 32'd0);
    end else if (out_valid && !stall) begin
      n_cons++;
      check("slot_pc", PC, exp_pc);
      check("slot_exc", 32'(out_exc), 32'(!legal(exp_pc)));
      check("slot_instr", instr, legal(exp_pc) ? word(exp_pc) : 32'h0);
      if (!legal(exp_pc)) blocked = 1'b1;
      else exp_pc = exp_pc + 32'd4;
    end
  end

  // One clock cycle: drive inputs just after the edge, sample at the falling edge,
  // then advance the memory model past the next rising edge.
  task automatic tick(input bit rst, input bit stl, input bit rdv, input logic [31:0] rpc);
    reset          = rst;
    stall          = stl;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    imem_ready     = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rvalid    = mem_busy && (mem_cnt == 0);
    imem_rdata     = imem_rvalid ? word(mem_addr) : $urandom;
    if (!rst || rdv) seg_q.push_back(!rst ? RESET_PC : rpc);
    @(negedge clk);
    s_rst   = reset;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_acc   = reset && imem_req && imem_ready;
    s_rsp   = imem_rvalid;
    s_ov    = out_valid;
    s_pc    = PC;
    s_instr = instr;
    s_exc   = out_exc;
    if (!reset) begin
      check("req_during_reset", 32'(imem_req), 32'd0);
    end else if (imem_req) begin
      check("req_addr_legal", 32'(legal(imem_addr)), 32'd1);
      check("req_one_outstanding", 32'(mem_busy), 32'd0);
    end
    @(posedge clk);
    #1;
    if (!s_rst) begin
      mem_busy = 1'b0;
    end else begin
      if (s_rsp) mem_busy = 1'b0;
      else if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (s_acc) begin
        mem_busy = 1'b1;
        mem_addr = s_addr;
        mem_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset state and first fetch.
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    check("rst_out_valid", 32'(s_ov), 32'd0);
    check("rst_pc", s_pc, 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_exc", 32'(s_exc), 32'd0);
    check("rst_req", 32'(s_req), 32'd0);
    tick(1, 0, 0, 0);
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, 32'h3000);
    tick(1, 0, 0, 0);
    check("wait_no_req", 32'(s_req), 32'd0);
    tick(1, 0, 0, 0);
    check("first_valid", 32'(s_ov), 32'd1);
    check("first_pc", s_pc, 32'h3000);
    check("first_instr", s_instr, 32'h2408_0001);
    check("second_req", 32'(s_req), 32'd1);
    check("second_addr", s_addr, 32'h3004);

    // Stall for 6 cycles: slot frozen on 0x3000, skid fills with 0x3004, requests stop.
    tick(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 0, 0);
      if (i >= 4) begin
        check("stall_no_req", 32'(s_req), 32'd0);
        check("stall_hold_valid", 32'(s_ov), 32'd1);
        check("stall_hold_pc", s_pc, 32'h3000);
        check("stall_hold_instr", s_instr, word(32'h3000));
      end
    end
    tick(1, 0, 0, 0);
    lat_fix = 3;
    tick(1, 0, 0, 0);
    check("skid_valid", 32'(s_ov), 32'd1);
    check("skid_pc", s_pc, 32'h3004);
    check("after_stall_addr", s_addr, 32'h3008);

    // Redirect while waiting on 0x3008: stale response dropped, refetch at 0x3100.
    tick(1, 0, 1, 32'h3100);
    tick(1, 0, 0, 0);
    check("drain_no_req", 32'(s_req), 32'd0);
    check("drain_flushed", 32'(s_ov), 32'd0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("drain_drop", 32'(s_ov), 32'd0);
    lat_fix = 0;
    tick(1, 0, 0, 0);
    check("redir_req", 32'(s_req), 32'd1);
    check("redir_addr", s_addr, 32'h3100);
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    check("redir_slot_valid", 32'(s_ov), 32'd1);
    check("redir_slot_pc", s_pc, 32'h3100);

    // Redirect coincident with rvalid and stall: no DRAIN.
    tick(1, 1, 1, 32'h3200);
    tick(1, 0, 1, 32'h3102);
    check("coinc_flushed", 32'(s_ov), 32'd0);
    check("coinc_req", 32'(s_req), 32'd1);
    check("coinc_addr", s_addr, 32'h3200);

    // Misaligned and out-of-range targets raise AdEL once each.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("bad_align_no_req", 32'(s_req), 32'd0);
    tick(1, 0, 0, 0);
    check("align_exc_valid", 32'(s_ov), 32'd1);
    check("align_exc", 32'(s_exc), 32'd1);
    check("align_exc_instr", s_instr, 32'h0);
    check("align_exc_pc", s_pc, 32'h3102);
    check("align_exc_no_req", 32'(s_req), 32'd0);
    tick(1, 0, 1, 32'h7000);
    check("exc_once", 32'(s_ov), 32'd0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("range_exc_valid", 32'(s_ov), 32'd1);
    check("range_exc", 32'(s_exc), 32'd1);
    check("range_exc_instr", s_instr, 32'h0);
    check("range_exc_pc", s_pc, 32'h7000);
    check("range_exc_no_req", 32'(s_req), 32'd0);

    // Reset asserted in WAIT with a full slot.
    tick(1, 0, 1, 32'h3000);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    lat_fix = 3;
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    check("pre_reset_slot_full", 32'(s_ov), 32'd1);
    tick(1, 0, 0, 0);
    check("midrst_valid", 32'(s_ov), 32'd0);
    check("midrst_pc", s_pc, 32'h0);
    check("midrst_instr", s_instr, 32'h0);
    check("midrst_exc", 32'(s_exc), 32'd0);
    check("midrst_req", 32'(s_req), 32'd1);
    check("midrst_addr", s_addr, 32'h3000);

    // Randomized traffic.
    lat_fix = -1;
    ready_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0:       tgt = 32'h3000 + 32'h2 + 32'($urandom_range(0, 32'h0FFF)) * 4;
        1:       tgt = ($urandom_range(0, 1) != 0) ? 32'h0000_7000 : 32'h0000_2FFC;
        default: tgt = LO + 32'($urandom_range(0, 32'h0FFF)) * 4;
      endcase
      tick($urandom_range(0, 499) != 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 29) == 0, tgt);
    end
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
    check("stream_progress", 32'(n_cons > 200), 32'd1);
    check("seg_queue_drained", 32'(seg_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
